// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file port controller.
//   AW/DW : register address / data width
//   NREG  : number of architectural registers
//   wb_entry_t : one buffered writeback {valid, addr, data}
package regfile_ctrl_pkg;
  localparam int AW   = 3;
  localparam int DW   = 16;
  localparam int NREG = 8;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_port_ctrl_wb_slot.sv
// wb_slot: single-entry writeback buffer for one writeback source.
//   clock, reset : clock, async active-high reset (discards the entry)
//   in_valid/in_addr/in_data : writeback request from the source
//   drain  : entry is granted the rf write port this cycle
//   ready  : handshake ready back to the source
//   fill   : handshake happens at this edge
//   entry  : current buffered contents
module wb_slot
  import regfile_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          drain,
  output logic          ready,
  output logic          fill,
  output wb_entry_t     entry
);

  // A draining slot can refill at the same edge, so each source
  // sustains one write per cycle.
  assign ready = !reset && (!entry.valid || drain);
  assign fill  = in_valid && ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry <= '0;
    end else if (fill) begin
      entry <= '{valid: 1'b1, addr: in_addr, data: in_data};
    end else if (drain) begin
      entry.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl: arbitrates the shared rb port of an 8x16 2R/1W
// register file between one operand reader and two writeback sources.
//   rd_*   : operand read request; rd_a/rd_b valid while rd_ready
//   wb0_*  : ALU writeback, buffered one deep
//   wb1_*  : load-unit writeback, buffered one deep
//   rf_*   : register file address/data/write; rf_ar/rf_br read data
//   busy   : any writeback still buffered
module regfile_port_ctrl #(
  parameter int AW           = regfile_ctrl_pkg::AW,
  parameter int DW           = regfile_ctrl_pkg::DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [AW-1:0] rd_ra,
  input  logic [AW-1:0] rd_rb,
  output logic [DW-1:0] rd_a,
  output logic [DW-1:0] rd_b,
  input  logic          wb0_valid,
  output logic          wb0_ready,
  input  logic [AW-1:0] wb0_addr,
  input  logic [DW-1:0] wb0_data,
  input  logic          wb1_valid,
  output logic          wb1_ready,
  input  logic [AW-1:0] wb1_addr,
  input  logic [DW-1:0] wb1_data,
  output logic [AW-1:0] rf_ra,
  output logic [AW-1:0] rf_rb,
  output logic          rf_write,
  output logic [DW-1:0] rf_data,
  input  logic [DW-1:0] rf_ar,
  input  logic [DW-1:0] rf_br,
  output logic          busy
);
  import regfile_ctrl_pkg::*;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wb_entry_t      s0, s1;
  logic           fill0, fill1;
  logic           grant0, grant1, rd_grant;
  logic           hazard, rd_prio, any_valid;
  logic           old_sel;
  logic [SW-1:0]  starve;

  wb_slot u_slot0 (
    .clock(clock), .reset(reset),
    .in_valid(wb0_valid), .in_addr(wb0_addr), .in_data(wb0_data),
    .drain(grant0), .ready(wb0_ready), .fill(fill0), .entry(s0)
  );

  wb_slot u_slot1 (
    .clock(clock), .reset(reset),
    .in_valid(wb1_valid), .in_addr(wb1_addr), .in_data(wb1_data),
    .drain(grant1), .ready(wb1_ready), .fill(fill1), .entry(s1)
  );

  // Only buffered writes are hazards; a write handshaking this cycle
  // is not yet visible, so a same-cycle read sees the old value.
  assign hazard = rd_valid &&
                  ((s0.valid && (rd_ra == s0.addr || rd_rb == s0.addr)) ||
                   (s1.valid && (rd_ra == s1.addr || rd_rb == s1.addr)));
  assign rd_prio   = rd_valid && !hazard && (starve == SW'(STARVE_LIMIT));
  assign any_valid = s0.valid || s1.valid;

  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    rd_grant = 1'b0;
    if (rd_prio || !any_valid) begin
      rd_grant = rd_valid && !hazard && !reset;
    end else if (s0.valid && s1.valid) begin
      grant0 = !old_sel;
      grant1 = old_sel;
    end else if (s0.valid) begin
      grant0 = 1'b1;
    end else begin
      grant1 = 1'b1;
    end
  end

  assign rf_write = grant0 || grant1;
  assign rf_ra    = rd_ra;
  assign rf_rb    = grant0 ? s0.addr : (grant1 ? s1.addr : rd_rb);
  assign rf_data  = grant0 ? s0.data : (grant1 ? s1.data : '0);
  assign rd_ready = rd_grant;
  assign rd_a     = rf_ar;
  assign rd_b     = rf_br;
  assign busy     = any_valid;

  // old_sel names the older slot. A slot filled while the other one
  // survives the edge becomes the younger; simultaneous fills put
  // slot0 first so same-register writes commit in handshake order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      old_sel <= 1'b0;
    end else if (fill0 && fill1) begin
      old_sel <= 1'b0;
    end else if (fill0 && s1.valid && !grant1) begin
      old_sel <= 1'b1;
    end else if (fill1 && s0.valid && !grant0) begin
      old_sel <= 1'b0;
    end
  end

  // Counts cycles a ready, hazard-free read loses to a write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve <= '0;
    end else if (!rd_valid || rd_grant) begin
      starve <= '0;
    end else if (!hazard && rf_write && starve != SW'(STARVE_LIMIT)) begin
      starve <= starve + SW'(1);
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
module tb_regfile_port_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        rd_valid, rd_ready;
  logic [2:0]  rd_ra, rd_rb;
  logic [15:0] rd_a, rd_b;
  logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [2:0]  wb0_addr, wb1_addr;
  logic [15:0] wb0_data, wb1_data;
  logic [2:0]  rf_ra, rf_rb;
  logic        rf_write;
  logic [15:0] rf_data, rf_ar, rf_br;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // register file model: r[i]=i at power-up, write through rb
  logic [15:0] rf [8];
  initial for (int i = 0; i < 8; i++) rf[i] = 16'(i);
  always @(posedge clock) if (rf_write) rf[rf_rb] <= rf_data;
  assign rf_ar = rf[rf_ra];
  assign rf_br = rf[rf_rb];

  always #5 clock = ~clock;

  regfile_port_ctrl dut (
    .clock(clock), .reset(reset),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ra(rd_ra), .rd_rb(rd_rb),
    .rd_a(rd_a), .rd_b(rd_b),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_write(rf_write), .rf_data(rf_data),
    .rf_ar(rf_ar), .rf_br(rf_br), .busy(busy)
  );

  task automatic idle_inputs();
    rd_valid = 0; rd_ra = 0; rd_rb = 0;
    wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
    wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    rd_valid = 1; wb0_valid = 1; wb1_valid = 1;
    repeat (2) @(negedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL reset_rf_write got=%b exp=0", rf_write); end
    total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL reset_rd_ready got=%b exp=0", rd_ready); end
    total++; if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
      bad++; $display("FAIL reset_wb_ready got=%b%b exp=00", wb0_ready, wb1_ready); end
    @(negedge clock);
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_read();
    @(negedge clock);
    rd_valid = 1; rd_ra = 2; rd_rb = 5;
    #1;
    total++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL read_ready got=%b exp=1", rd_ready); end
    total++; if (rd_a !== 16'h0002) begin bad++; $display("FAIL read_a got=%h exp=0002", rd_a); end
    total++; if (rd_b !== 16'h0005) begin bad++; $display("FAIL read_b got=%h exp=0005", rd_b); end
    total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL read_no_write got=%b exp=0", rf_write); end
  endtask

  task automatic test_write();
    @(negedge clock);
    idle_inputs();
    wb0_valid = 1; wb0_addr = 3; wb0_data = 16'hBEEF;
    #1;
    total++; if (wb0_ready !== 1'b1) begin bad++; $display("FAIL write_wb0_ready got=%b exp=1", wb0_ready); end
    @(negedge clock);
    wb0_valid = 0;
    #1;
    total++; if (rf_write !== 1'b1 || rf_rb !== 3'd3 || rf_data !== 16'hBEEF) begin
      bad++; $display("FAIL write_port got=w%b rb%0d d%h exp=w1 rb3 dbeef", rf_write, rf_rb, rf_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL write_busy got=%b exp=1", busy); end
    @(negedge clock);
    rd_valid = 1; rd_ra = 3; rd_rb = 0;
    #1;
    total++; if (rd_ready !== 1'b1 || rd_a !== 16'hBEEF) begin
      bad++; $display("FAIL write_readback got=r%b a%h exp=r1 abeef", rd_ready, rd_a); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL write_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_order();
    @(negedge clock);
    idle_inputs();
    wb0_valid = 1; wb0_addr = 1; wb0_data = 16'h1111;
    wb1_valid = 1; wb1_addr = 1; wb1_data = 16'h2222;
    #1;
    total++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b1) begin
      bad++; $display("FAIL order_ready got=%b%b exp=11", wb0_ready, wb1_ready); end
    @(negedge clock);
    wb0_valid = 0; wb1_valid = 0;
    #1;
    total++; if (rf_write !== 1'b1 || rf_rb !== 3'd1 || rf_data !== 16'h1111) begin
      bad++; $display("FAIL order_first got=w%b rb%0d d%h exp=w1 rb1 d1111", rf_write, rf_rb, rf_data); end
    @(negedge clock);
    #1;
    total++; if (rf_write !== 1'b1 || rf_rb !== 3'd1 || rf_data !== 16'h2222) begin
      bad++; $display("FAIL order_second got=w%b rb%0d d%h exp=w1 rb1 d2222", rf_write, rf_rb, rf_data); end
    @(negedge clock);
    rd_valid = 1; rd_ra = 1; rd_rb = 2;
    #1;
    total++; if (rd_ready !== 1'b1 || rd_a !== 16'h2222) begin
      bad++; $display("FAIL order_readback got=r%b a%h exp=r1 a2222", rd_ready, rd_a); end
  endtask

  task automatic test_hazard();
    @(negedge clock);
    idle_inputs();
    wb1_valid = 1; wb1_addr = 4; wb1_data = 16'h4444;
    @(negedge clock);
    wb1_valid = 0;
    rd_valid = 1; rd_ra = 4; rd_rb = 0;
    #1;
    total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL hazard_stall got=%b exp=0", rd_ready); end
    total++; if (rf_write !== 1'b1 || rf_rb !== 3'd4 || rf_data !== 16'h4444) begin
      bad++; $display("FAIL hazard_drain got=w%b rb%0d d%h exp=w1 rb4 d4444", rf_write, rf_rb, rf_data); end
    @(negedge clock);
    #1;
    total++; if (rd_ready !== 1'b1 || rd_a !== 16'h4444) begin
      bad++; $display("FAIL hazard_release got=r%b a%h exp=r1 a4444", rd_ready, rd_a); end
  endtask

  task automatic test_starve();
    int c0 = 0, c1 = 0;
    logic exp_rd [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    idle_inputs();
    for (int cyc = 0; cyc < 13; cyc++) begin
      @(negedge clock);
      wb0_valid = 1; wb0_addr = 3'(c0 % 3);     wb0_data = 16'(16'hA000 + c0);
      wb1_valid = 1; wb1_addr = 3'(3 + c1 % 3); wb1_data = 16'(16'hB000 + c1);
      if (cyc >= 3) begin rd_valid = 1; rd_ra = 6; rd_rb = 7; end
      #1;
      if (cyc >= 3) begin
        total++;
        if (rd_ready !== exp_rd[cyc-3] || rf_write !== !exp_rd[cyc-3]) begin
          bad++;
          $display("FAIL starve_cycle%0d got=r%b w%b exp=r%b w%b", cyc - 3, rd_ready, rf_write,
                   exp_rd[cyc-3], !exp_rd[cyc-3]);
        end
      end
      if (wb0_ready) c0++;
      if (wb1_ready) c1++;
    end
    @(negedge clock);
    idle_inputs();
    repeat (3) @(negedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL starve_drained got=%b exp=0", busy); end
  endtask

  task automatic test_reset_midcycle();
    @(negedge clock);
    idle_inputs();
    wb0_valid = 1; wb0_addr = 6; wb0_data = 16'hAAAA;
    wb1_valid = 1; wb1_addr = 7; wb1_data = 16'hBBBB;
    @(negedge clock);
    wb0_valid = 0; wb1_valid = 0;
    #1;
    total++; if (busy !== 1'b1 || rf_write !== 1'b1) begin
      bad++; $display("FAIL midreset_pre got=b%b w%b exp=b1 w1", busy, rf_write); end
    rd_valid = 1; rd_ra = 0; rd_rb = 1; wb0_valid = 1;
    #1 reset = 1;
    #1;
    total++; if (busy !== 1'b0 || rf_write !== 1'b0) begin
      bad++; $display("FAIL midreset_drop got=b%b w%b exp=b0 w0", busy, rf_write); end
    total++; if (rd_ready !== 1'b0 || wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_ready got=%b%b%b exp=000", rd_ready, wb0_ready, wb1_ready); end
    @(negedge clock);
    idle_inputs();
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      #1;
      total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL midreset_nowrite%0d got=%b exp=0", i, rf_write); end
    end
    @(negedge clock);
    rd_valid = 1; rd_ra = 6; rd_rb = 7;
    #1;
    total++; if (rd_ready !== 1'b1 || rd_a !== 16'h0006 || rd_b !== 16'h0007) begin
      bad++; $display("FAIL midreset_regs got=r%b a%h b%h exp=r1 a0006 b0007", rd_ready, rd_a, rd_b); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_order();
    test_hazard();
    test_starve();
    test_reset_midcycle();
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_port_ctrl.md
Name: regfile_port_ctrl

Overview:
Port controller for the 8x16 two-read/one-write register file. The register file writes through its rb address, so operand reads and writebacks compete for the same port. This block arbitrates one operand-read requester (decode) against two writeback requesters (wb0 = ALU, wb1 = load unit). It buffers one writeback per source, preserves write order, stalls reads on RAW hazards against buffered writes, and bounds read starvation.

Parameters:
AW, 3, register address width
DW, 16, data width
STARVE_LIMIT, 4, consecutive cycles a ready, hazard-free read may lose to writes before it takes priority

Ports:
clock  in  1  system clock
reset  in  1  reset
rd_valid  in  1  operand read request
rd_ready  out  1  read granted this cycle; rd_a/rd_b valid in this cycle
rd_ra  in  AW  first operand address
rd_rb  in  AW  second operand address
rd_a  out  DW  first operand data
rd_b  out  DW  second operand data
wb0_valid  in  1  ALU writeback request
wb0_ready  out  1  wb0 accepted at this edge
wb0_addr  in  AW  ALU destination register
wb0_data  in  DW  ALU result
wb1_valid, wb1_ready, wb1_addr, wb1_data  same roles for the load unit
rf_ra  out  AW  to register file ra
rf_rb  out  AW  to register file rb (read or write address)
rf_write  out  1  to register file write
rf_data  out  DW  to register file data
rf_ar  in  DW  from register file ar
rf_br  in  DW  from register file br
busy  out  1  any writeback buffered

Behaviour:
- Interface: reset is named reset, asynchronous, active-high. Clock is clock. All state updates on posedge clock.
- State: two 1-entry slots (valid, addr, data), old_sel (which slot is older), starve counter (saturates at STARVE_LIMIT).
- Reset (async): slots empty, old_sel=0, starve=0. While reset is high, force rf_write=0, rd_ready=0, wb0_ready=0, wb1_ready=0, busy=0. Buffered writes are discarded on reset.
- Hazard: rd_valid and (rd_ra or rd_rb) equals the addr of any valid slot.
- Read priority: rd_valid, no hazard, and starve==STARVE_LIMIT.
- Grant, combinational each cycle:
  - If read priority holds, or no slot is valid: grant the read when rd_valid and no hazard.
  - Otherwise grant a write. If only one slot is valid, grant that slot. If both are valid, grant slot old_sel.
- Write grant: rf_write=1, rf_rb=slot addr, rf_data=slot data, rd_ready=0. The register file commits at the edge, and the slot clears at the same edge.
- Read grant: rf_write=0, rf_ra=rd_ra, rf_rb=rd_rb, rd_ready=1, rd_a=rf_ar, rd_b=rf_br. These are zero-latency combinational reads.
- Idle: rf_write=0, rf_ra=rd_ra, rf_rb=rd_rb.
- wbN_ready = !slotN.valid or slotN granted this cycle. Drain and refill in the same cycle is allowed, giving one write per cycle per source.
- Age tracking:
  - Both slots filled at one edge from empty: slot0 is older.
  - A slot filled while the other slot stays valid: the other slot becomes older.
  - Result: writes to the same register commit in handshake order.
- Same-cycle ordering: a read granted in the cycle of a wb handshake sees the pre-write value. Hazard checks cover buffered slots only.
- Starve counter:
  - Increments when rd_valid, no hazard, and a write is granted.
  - Clears on a read grant or when rd_valid=0.
  - Holds when a hazard is present.
- busy = slot0.valid or slot1.valid.
- rf_data=0 whenever rf_write=0.

Decomposition:
- Package regfile_ctrl_pkg: AW, DW, NREG=8, and a packed wb_entry_t {valid, addr, data}.
- Sub-module wb_slot, instantiated twice. It is the 1-entry buffer with fill/drain and ready logic.
- Arbitration, hazard, age and starve logic stay in regfile_port_ctrl.

Test Plan:
1. Reset released; rd_valid=1, rd_ra=2, rd_rb=5, no writes -> rd_ready=1 in the same cycle, rd_a=0x0002, rd_b=0x0005 (register file resets r[i]=i).
2. wb0 handshake addr=3, data=0xBEEF -> next cycle rf_write=1, rf_rb=3, rf_data=0xBEEF. The cycle after, a read of r3 returns 0xBEEF.
3. wb0 (addr 1, 0x1111) and wb1 (addr 1, 0x2222) handshake in the same cycle -> 0x1111 is written first, 0x2222 one cycle later; a later read of r1 returns 0x2222.
4. wb1 buffered to addr 4, then rd_ra=4 -> rd_ready=0 until the slot drains. In the next cycle rd_ready=1 and rd_a is the new value.
5. Both sources write every cycle to addrs 0..5; rd_valid held with ra=6, rb=7 -> reads lose for exactly 4 cycles, then rd_ready=1 in the 5th cycle and starve returns to 0.
6. Both slots full, then reset asserted mid-cycle -> busy, rf_write and all readies drop to 0 immediately. After release no buffered write reaches the register file.
